// File: rtl/ram_pkg.sv
// Shared types, limits and helpers for the pipelined single-port RAM.
package ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int MAX_RD_LATENCY = 4;

  // Even parity: stored bit makes the total count of ones in byte+bit even.
  function automatic logic parity_byte(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_sp_pipelined_if.sv
// Request/response bundle for ram_sp_pipelined; master drives requests, slave answers.
interface ram_sp_pipelined_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
);
  logic                      en;
  logic                      wr_rd;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [DATA_WIDTH/8-1:0]   be;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      out_en;
  logic                      par_err;

  modport master (
    output en, wr_rd, addr, data_in, be,
    input  ready, data_out, out_en, par_err
  );

  modport slave (
    input  en, wr_rd, addr, data_in, be,
    output ready, data_out, out_en, par_err
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Fixed-latency valid/data delay line; data stages only load on valid so the
// last stage holds the most recent result. rst clears every stage.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  if (LATENCY < 1 || LATENCY > MAX_RD_LATENCY) begin : gen_bad_latency
    $error("ram_rd_pipe: LATENCY out of range");
  end

  logic [LATENCY-1:0] valid_reg;
  logic [WIDTH-1:0]   data_reg [LATENCY];

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[LATENCY-1];
  assign out_data  = data_reg[LATENCY-1];
endmodule

// File: rtl/ram_sp_pipelined.sv
// Single-port RAM with byte enables, post-reset clearing sweep and RD_LATENCY read pipe.
// Optional per-lane even parity storage/check when RAM_PARITY_EN is defined.
module ram_sp_pipelined
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  ram_sp_pipelined_if.slave bus
);
  localparam int                    BE_W     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic                  ready_w;
  logic                  accept;
  logic                  in_range;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_W-1:0]       wr_lanes;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  out_en_w;
  logic [DATA_WIDTH-1:0] data_out_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    ready_w    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        ptr_next = ptr_reg + ADDR_WIDTH'(1);
        if (ptr_reg == PTR_LAST) begin
          state_next = ST_RUN;
        end
      end
      default: ready_w = 1'b1;
    endcase
  end

  assign in_range = int'(bus.addr) < DEPTH;
  assign accept   = bus.en && ready_w && !rst;
  assign rd_fire  = accept && !bus.wr_rd;

  // The sweep and normal writes share one write port.
  always_comb begin
    wr_addr  = bus.addr;
    wr_data  = bus.data_in;
    wr_lanes = '0;
    if (rst) begin
      wr_lanes = '0;
    end else if (state_reg == ST_INIT) begin
      wr_addr  = ptr_reg;
      wr_data  = '0;
      wr_lanes = '1;
    end else if (accept && bus.wr_rd && in_range) begin
      wr_lanes = bus.be;
    end
  end

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
`ifdef RAM_PARITY_EN
        par_mem[wr_addr][i] <= parity_byte(wr_data[i*8 +: 8]);
`endif
      end
    end
  end

  assign rd_word = in_range ? mem[bus.addr] : '0;

  ram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (RD_LATENCY)
  ) u_data_pipe (
    .clk       (clk),
    .srst      (rst),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .out_valid (out_en_w),
    .out_data  (data_out_w)
  );

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] rd_par;
  logic [BE_W-1:0] lane_bad;
  logic            par_valid;
  logic            par_data;

  assign rd_par = in_range ? par_mem[bus.addr] : '0;

  for (genvar gi = 0; gi < BE_W; gi++) begin : gen_par_chk
    assign lane_bad[gi] = parity_byte(rd_word[gi*8 +: 8]) != rd_par[gi];
  end

  ram_rd_pipe #(
    .WIDTH   (1),
    .LATENCY (RD_LATENCY)
  ) u_par_pipe (
    .clk       (clk),
    .srst      (rst),
    .in_valid  (rd_fire),
    .in_data   (|lane_bad),
    .out_valid (par_valid),
    .out_data  (par_data)
  );

  // The data stage holds between reads, so qualify with valid to keep par_err a pulse.
  assign bus.par_err = par_valid && par_data;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.ready    = ready_w;
  assign bus.out_en   = out_en_w;
  assign bus.data_out = data_out_w;
endmodule

// File: tb/tb_ram_sp_pipelined.sv
// Directed bench for ram_sp_pipelined: reference model + expected-read queue per DUT.
module tb_ram_sp_pipelined;
  import ram_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int D0  = 16;
  localparam int D1  = 12;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_sp_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  ram_sp_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  ram_sp_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D0), .RD_LATENCY(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  ram_sp_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D1), .RD_LATENCY(LAT)) dut12 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  exp_t          q0[$];
  exp_t          q1[$];
  exp_t          e0, e1;
  logic [DW-1:0] model0 [D0];
  logic [DW-1:0] model1 [D1];
  logic [1:0]    bad1   [D1];
  int            cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < D0; i++) model0[i] = '0;
    for (int i = 0; i < D1; i++) begin
      model1[i] = '0;
      bad1[i]   = '0;
    end
  endtask

  // Called #1 after a rising edge; the request is accepted at the next edge.
  task automatic req(input bit b, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [1:0] bev);
    exp_t e;
    int   depth;
    bit   inr;
    depth = b ? D1 : D0;
    inr   = int'(a) < depth;
    if (!b) begin
      bus0.en = 1'b1; bus0.wr_rd = wr; bus0.addr = a; bus0.data_in = d; bus0.be = bev;
    end else begin
      bus1.en = 1'b1; bus1.wr_rd = wr; bus1.addr = a; bus1.data_in = d; bus1.be = bev;
    end
    if (wr) begin
      if (inr) begin
        for (int l = 0; l < 2; l++) begin
          if (bev[l]) begin
            if (b) begin
              model1[a][l*8 +: 8] = d[l*8 +: 8];
              bad1[a][l] = 1'b0;
            end else begin
              model0[a][l*8 +: 8] = d[l*8 +: 8];
            end
          end
        end
      end
    end else begin
      e.data = !inr ? '0 : (b ? model1[a] : model0[a]);
      e.par  = b && inr && (|bad1[a]);
      e.cyc  = cyc + LAT;
      if (b) q1.push_back(e);
      else   q0.push_back(e);
    end
    $display("req  bus%0d %s addr=%0d data=%h be=%b cyc=%0d", b, wr ? "WR" : "RD", a, d, bev, cyc);
    @(posedge clk);
    #1;
    bus0.en = 1'b0;
    bus1.en = 1'b0;
  endtask

`ifdef RAM_PARITY_EN
  task automatic mem_force_parity(input int a, input int lane);
    dut12.par_mem[a][lane] <= ~dut12.par_mem[a][lane];
    bad1[a][lane] = ~bad1[a][lane];
    $display("inj  bus1 parity flip addr=%0d lane=%0d", a, lane);
  endtask
`endif

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending_reads", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus0.ready !== 1'b1 && n < 100);
    check(tag, n, D0);
  endtask

  always @(negedge clk) begin
    if (bus0.out_en === 1'b1) begin
      if (q0.size() == 0) begin
        check("spurious_out_en_bus0", 1, 0);
      end else begin
        e0 = q0.pop_front();
        $display("resp bus0 data=%h par_err=%b cyc=%0d", bus0.data_out, bus0.par_err, cyc);
        check("rd_data_bus0", bus0.data_out, e0.data);
        check("par_err_bus0", bus0.par_err, e0.par);
        check("rd_latency_bus0", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.out_en === 1'b1) begin
      if (q1.size() == 0) begin
        check("spurious_out_en_bus1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        $display("resp bus1 data=%h par_err=%b cyc=%0d", bus1.data_out, bus1.par_err, cyc);
        check("rd_data_bus1", bus1.data_out, e1.data);
        check("par_err_bus1", bus1.par_err, e1.par);
        check("rd_latency_bus1", cyc, e1.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus0.en = 1'b0; bus0.wr_rd = 1'b0; bus0.addr = '0; bus0.data_in = '0; bus0.be = '0;
    bus1.en = 1'b0; bus1.wr_rd = 1'b0; bus1.addr = '0; bus1.data_in = '0; bus1.be = '0;
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", bus0.ready, 0);
    check("reset_out_en", bus0.out_en, 0);
    check("reset_data_out", bus0.data_out, 0);
    check("reset_par_err", bus0.par_err, 0);
    check("reset_ready_bus1", bus1.ready, 0);

    // Sweep length and cleared contents
    rst = 1'b0;
    wait_ready("init_ready_cycles");
    check("ready_bus1_after_sweep", bus1.ready, 1);
    for (int a = 0; a < D0; a++) req(0, 0, AW'(a), '0, 2'b00);
    drain();

    // Read latency and data hold
    req(0, 1, 4'd3, 16'hBEEF, 2'b11);
    req(0, 0, 4'd3, '0, 2'b00);
    drain();
    check("hold_data_out", bus0.data_out, 16'hBEEF);
    check("hold_out_en_low", bus0.out_en, 0);

    // Byte enables
    req(0, 1, 4'd5, 16'h1234, 2'b11);
    req(0, 1, 4'd5, 16'hABCD, 2'b01);
    req(0, 0, 4'd5, '0, 2'b00);
    req(0, 1, 4'd5, 16'hFFFF, 2'b00);
    req(0, 0, 4'd5, '0, 2'b00);
    drain();

    // Read then write same address back-to-back
    req(0, 0, 4'd7, '0, 2'b00);
    req(0, 1, 4'd7, 16'h5555, 2'b11);
    req(0, 0, 4'd7, '0, 2'b00);
    drain();

    // Reset with a read in flight
    req(0, 1, 4'd2, 16'h7777, 2'b11);
    req(0, 0, 4'd2, '0, 2'b00);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    clear_models();
    @(posedge clk);
    #1;
    check("midflight_reset_ready", bus0.ready, 0);
    check("midflight_reset_out_en", bus0.out_en, 0);
    rst = 1'b0;
    wait_ready("resweep_ready_cycles");
    req(0, 0, 4'd2, '0, 2'b00);
    req(0, 0, 4'd3, '0, 2'b00);
    req(0, 0, 4'd5, '0, 2'b00);
    drain();

    // Out-of-range access on the DEPTH=12 instance
    req(1, 1, 4'd14, 16'hFFFF, 2'b11);
    req(1, 0, 4'd14, '0, 2'b00);
    req(1, 0, 4'd11, '0, 2'b00);
`ifdef RAM_PARITY_EN
    req(1, 1, 4'd4, 16'h3C5A, 2'b11);
    mem_force_parity(4, 1);
    req(1, 0, 4'd4, '0, 2'b00);
    req(1, 0, 4'd3, '0, 2'b00);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
